ret_controller: RTL
===================

Name: ret_controller

Overview:
Return-path sequencer for the pipelined processor, the counterpart to the call/interrupt push path. On a RET or RTI from the memory stage it stalls fetch/decode and pops the saved PC from the stack (two 16-bit words), plus the flags word for RTI. It then loads the PC and flags, writes back the updated SP, and flushes the wrong-path instructions. It sits beside the flush controller and drives the PC mux, the SP register, the CCR and the data-memory read port.

Parameters:
DATA_W, 16, memory word width; the PC is 2*DATA_W bits.
ADDR_W, 32, SP and memory address width.
FLAG_W, 3, CCR width; flags are taken from the low FLAG_W bits of the popped word.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  synchronous reset, active-low: rst==0 at a posedge resets the block.
ret  in  1  RET in memory stage; sampled only in IDLE.
rti  in  1  RTI in memory stage; sampled only in IDLE; wins over ret if both are high.
sp_in  in  ADDR_W  current SP; latched at trigger.
mem_rdata  in  DATA_W  memory read data; valid the cycle after mem_rd.
mem_rd  out  1  memory read request.
mem_addr  out  ADDR_W  read address.
pc_out  out  2*DATA_W  popped PC as {hi,lo}.
pc_load  out  1  one-cycle PC load strobe.
flags_out  out  FLAG_W  popped flags.
flags_load  out  1  one-cycle CCR load strobe (RTI only).
sp_out  out  ADDR_W  new SP.
sp_wr  out  1  one-cycle SP write strobe.
stall  out  1  freeze fetch/decode.
flush  out  1  flush IF/ID and ID/EX.
busy  out  1  sequence in progress.

Behaviour:
- Reset (rst==0 at a posedge): state IDLE; every output 0; internal pc_q, flags_q, addr_q, sp_q and is_rti cleared. Reset mid-sequence aborts with no pc_load, sp_wr or flags_load.
- Stack addressing: the stack grows down and a pop reads SP+1. Pop order is PC low word, PC high word, then flags (RTI only).
- IDLE: all outputs 0. On (ret|rti) at a posedge:
  - is_rti <= rti.
  - addr_q <= sp_in+1.
  - sp_q <= sp_in + (rti ? 3 : 2).
  - Next state POP_LO.
- POP_LO: mem_rd=1, mem_addr=addr_q; addr_q++. Next POP_HI.
- POP_HI: mem_rd=1, mem_addr=addr_q; pc_q[DATA_W-1:0] <= mem_rdata; addr_q++. Next POP_FLG if is_rti, else CAPT.
- POP_FLG: mem_rd=1, mem_addr=addr_q; pc_q[hi] <= mem_rdata. Next CAPT.
- CAPT: mem_rd=0.
  - RET: pc_q[hi] <= mem_rdata.
  - RTI: flags_q <= mem_rdata[FLAG_W-1:0].
  - Next LOAD.
- LOAD:
  - pc_load=1, pc_out=pc_q.
  - sp_wr=1, sp_out=sp_q.
  - flags_load=is_rti, flags_out=flags_q.
  - flush=1.
  - Next DRAIN.
- DRAIN: flush=1, stall=0. Next IDLE.
- stall=1 and busy=1 in POP_LO through LOAD; busy=1 also in DRAIN.
- Latency, counting the trigger edge as cycle 0:
  - RET: LOAD in cycle 4, back in IDLE in cycle 6.
  - RTI: LOAD in cycle 5, back in IDLE in cycle 7.
- ret/rti arriving while not in IDLE are ignored; a trigger is accepted again in the cycle the block is back in IDLE.
- Arithmetic is modulo 2^ADDR_W: sp_in all-ones gives a first pop address of 0.
- pc_out and flags_out hold their last values outside LOAD; consumers must qualify them with the strobes.
- The state register is encoded with enough bits for all 7 states.

Decomposition:
- Shared package ret_ctrl_pkg holds:
  - the state encoding: IDLE, POP_LO, POP_HI, POP_FLG, CAPT, LOAD, DRAIN;
  - RET_POPS=2 and RTI_POPS=3.
- Single module, no sub-module. The next-state/output logic and the registered datapath (pc_q, flags_q, addr_q, sp_q) are small enough to keep together.

Test Plan:
- RET: sp_in=0x000003FC; memory[0x3FD]=0x1234, memory[0x3FE]=0x00AB. Pulse ret. Required: mem_addr 0x3FD then 0x3FE; pc_load in cycle 4 with pc_out=0x00AB1234; sp_out=0x000003FE with sp_wr; flags_load=0; flush high in cycles 4-5; stall high in cycles 1-4.
- RTI: sp_in=0x00000FF0; memory[0xFF1..0xFF3]=0x5678, 0x0001, 0x0005. Pulse rti. Required: pc_out=0x00015678 and flags_out=3'b101 in cycle 5, with flags_load=1; sp_out=0x00000FF3.
- ret and rti asserted together → RTI sequence (three reads, flags_load=1).
- ret re-pulsed during POP_HI → ignored: exactly one pc_load, and busy falls after DRAIN.
- rst=0 during CAPT → next cycle every output is 0 and state is IDLE; no pc_load or sp_wr ever pulses. A later ret works normally.
- Wrap: sp_in=0xFFFFFFFF with ret → reads at 0x00000000 and 0x00000001; sp_out=0x00000001.

Source files
------------

// File: rtl/ret_ctrl_pkg.sv
// Shared definitions for the return-path sequencer: state encoding and pop counts.
package ret_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    POP_LO  = 3'd1,
    POP_HI  = 3'd2,
    POP_FLG = 3'd3,
    CAPT    = 3'd4,
    LOAD    = 3'd5,
    DRAIN   = 3'd6
  } state_e;

  localparam int unsigned RET_POPS = 2;
  localparam int unsigned RTI_POPS = 3;

endpackage

// File: rtl/ret_controller.sv
// Return-path sequencer: pops PC (and flags for RTI) off the stack, then loads
// PC/SP/CCR and flushes the wrong-path instructions.
module ret_controller
  import ret_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 32,
  parameter int FLAG_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ret,
  input  logic                rti,
  input  logic [ADDR_W-1:0]   sp_in,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_rd,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [2*DATA_W-1:0] pc_out,
  output logic                pc_load,
  output logic [FLAG_W-1:0]   flags_out,
  output logic                flags_load,
  output logic [ADDR_W-1:0]   sp_out,
  output logic                sp_wr,
  output logic                stall,
  output logic                flush,
  output logic                busy
);

  state_e                state_q, state_d;
  logic                  is_rti_q, is_rti_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [ADDR_W-1:0]     sp_q, sp_d;
  logic [2*DATA_W-1:0]   pc_q, pc_d;
  logic [FLAG_W-1:0]     flags_q, flags_d;

  logic                  mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [2*DATA_W-1:0]   pc_out_q, pc_out_d;
  logic                  pc_load_q, pc_load_d;
  logic [FLAG_W-1:0]     flags_out_q, flags_out_d;
  logic                  flags_load_q, flags_load_d;
  logic [ADDR_W-1:0]     sp_out_q, sp_out_d;
  logic                  sp_wr_q, sp_wr_d;
  logic                  stall_q, stall_d;
  logic                  flush_q, flush_d;
  logic                  busy_q, busy_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d  = state_q;
    is_rti_d = is_rti_q;
    addr_d   = addr_q;
    sp_d     = sp_q;
    pc_d     = pc_q;
    flags_d  = flags_q;

    unique case (state_q)
      IDLE: begin
        if (ret || rti) begin
          is_rti_d = rti;
          addr_d   = sp_in + ADDR_W'(1);
          sp_d     = sp_in + ADDR_W'(rti ? RTI_POPS : RET_POPS);
          state_d  = POP_LO;
        end
      end
      POP_LO: begin
        addr_d  = addr_q + ADDR_W'(1);
        state_d = POP_HI;
      end
      POP_HI: begin
        pc_d[DATA_W-1:0] = mem_rdata;
        addr_d           = addr_q + ADDR_W'(1);
        state_d          = is_rti_q ? POP_FLG : CAPT;
      end
      POP_FLG: begin
        pc_d[2*DATA_W-1:DATA_W] = mem_rdata;
        state_d                 = CAPT;
      end
      CAPT: begin
        if (is_rti_q) flags_d = mem_rdata[FLAG_W-1:0];
        else          pc_d[2*DATA_W-1:DATA_W] = mem_rdata;
        state_d = LOAD;
      end
      LOAD:    state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered in the
  // same cycle the FSM occupies the corresponding state.
  always_comb begin
    mem_rd_d     = (state_d == POP_LO) || (state_d == POP_HI) || (state_d == POP_FLG);
    mem_addr_d   = mem_rd_d ? addr_d : '0;
    pc_load_d    = (state_d == LOAD);
    sp_wr_d      = pc_load_d;
    flags_load_d = pc_load_d && is_rti_d;
    pc_out_d     = pc_load_d ? pc_d    : pc_out_q;
    sp_out_d     = pc_load_d ? sp_d    : sp_out_q;
    flags_out_d  = pc_load_d ? flags_d : flags_out_q;
    stall_d      = mem_rd_d || (state_d == CAPT) || (state_d == LOAD);
    flush_d      = (state_d == LOAD) || (state_d == DRAIN);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only; the reset here
    // is synchronous, so it is just the highest-priority branch of the edge.
    if (!rst) begin
      state_q      <= IDLE;
      is_rti_q     <= 1'b0;
      addr_q       <= '0;
      sp_q         <= '0;
      pc_q         <= '0;
      flags_q      <= '0;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= '0;
      pc_out_q     <= '0;
      pc_load_q    <= 1'b0;
      flags_out_q  <= '0;
      flags_load_q <= 1'b0;
      sp_out_q     <= '0;
      sp_wr_q      <= 1'b0;
      stall_q      <= 1'b0;
      flush_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_rti_q     <= is_rti_d;
      addr_q       <= addr_d;
      sp_q         <= sp_d;
      pc_q         <= pc_d;
      flags_q      <= flags_d;
      mem_rd_q     <= mem_rd_d;
      mem_addr_q   <= mem_addr_d;
      pc_out_q     <= pc_out_d;
      pc_load_q    <= pc_load_d;
      flags_out_q  <= flags_out_d;
      flags_load_q <= flags_load_d;
      sp_out_q     <= sp_out_d;
      sp_wr_q      <= sp_wr_d;
      stall_q      <= stall_d;
      flush_q      <= flush_d;
      busy_q       <= busy_d;
    end
  end

  assign mem_rd     = mem_rd_q;
  assign mem_addr   = mem_addr_q;
  assign pc_out     = pc_out_q;
  assign pc_load    = pc_load_q;
  assign flags_out  = flags_out_q;
  assign flags_load = flags_load_q;
  assign sp_out     = sp_out_q;
  assign sp_wr      = sp_wr_q;
  assign stall      = stall_q;
  assign flush      = flush_q;
  assign busy       = busy_q;

endmodule
